// File: rtl/serial_adder_n_pkg.sv
// Shared constants for the bit-serial adder/subtractor: FSM encodings and
// the default operand width.
package serial_adder_n_pkg;

  // FSM state encodings; 2'd3 is unused and decodes to IDLE.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Default operand/result width.
  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_n_if.sv
// Request/result bundle of the serial adder. The master drives the request
// and operands; the slave (the adder) returns status and result.
interface serial_adder_n_if #(
  parameter int WIDTH = serial_adder_n_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/serial_adder_n_full_adder_bit.sv
// One-bit full adder built from two half adders and an OR gate. This is the
// single arithmetic slice the serial adder reuses every RUN cycle.
module half_adder (
  output logic s,
  output logic c,
  input  logic x,
  input  logic y
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

module full_adder_bit (
  output logic s,
  output logic co,
  input  logic x,
  input  logic y,
  input  logic ci
);

  logic s0_s;
  logic c0_s;
  logic c1_s;

  half_adder u_ha0 (.s(s0_s), .c(c0_s), .x(x),    .y(y));
  half_adder u_ha1 (.s(s),    .c(c1_s), .x(s0_s), .y(ci));

  assign co = c0_s | c1_s;

endmodule

// File: rtl/serial_adder_n.sv
// Bit-serial adder/subtractor. Operands are latched on an accepted start and
// processed LSB first through one full-adder slice, one bit per clock, with
// the carry held in a flip-flop. Result is valid from the done pulse and
// held until the next accepted start.
module serial_adder_n
  import serial_adder_n_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic            clk,
  input  logic            reset,
  serial_adder_n_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             cout_r;
  logic             ovf_r;
  logic             busy_r;
  logic             done_r;
  logic             slice_s_s;
  logic             slice_co_s;
  logic             last_s;

  full_adder_bit u_fa (
    .s  (slice_s_s),
    .co (slice_co_s),
    .x  (a_sh_r[0]),
    .y  (b_sh_r[0]),
    .ci (carry_r)
  );

  assign last_s = (cnt_r == CNT_LAST);

  // Next-state decode; the illegal encoding falls back to IDLE.
  always_comb begin
    state_nxt_s = S_IDLE;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt_s = S_RUN;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_s) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath: operand load on accept, one bit per RUN cycle, flags on the last bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r   <= {CW{1'b0}};
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        S_RUN: begin
          sum_r   <= {slice_s_s, sum_r[WIDTH-1:1]};
          a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
          carry_r <= slice_co_s;
          cnt_r   <= cnt_r + CNT_ONE;
          if (last_s) begin
            // Carry into the MSB is the carry FF of this cycle.
            cout_r <= slice_co_s;
            ovf_r  <= carry_r ^ slice_co_s;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else begin
            busy_r <= 1'b1;
            done_r <= 1'b0;
          end
        end
        S_DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
        default: begin
          // IDLE (and the illegal encoding): wait for a request.
          done_r <= 1'b0;
          if ((state_r == S_IDLE) && bus.start) begin
            a_sh_r  <= bus.a;
            // Subtraction is a + ~b + 1; cin is ignored in that mode.
            b_sh_r  <= bus.sub ? ~bus.b : bus.b;
            carry_r <= bus.sub ? 1'b1 : bus.cin;
            cnt_r   <= {CW{1'b0}};
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;

endmodule
